// File: rtl/gun_hit_detector.sv
// Light-gun front end: synchronises and debounces the trigger, then watches the photodiode
// during the target-flash frames and reports hit or miss to the target drawer and game logic.
module gun_hit_detector #(
    parameter int DEBOUNCE_CYCLES   = 65000,
    parameter int TARGET_FRAMES     = 10,
    parameter int SENSE_START_FRAME = 2,
    parameter int LIGHT_MIN_CYCLES  = 500
) (
    input  logic clk,
    input  logic rst,
    input  logic trigger_in,
    input  logic light_in,
    input  logic gun_is_connected,
    input  logic new_frame,
    output logic shot_fired,
    output logic duck_hit,
    output logic shot_missed,
    output logic busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FW = $clog2(TARGET_FRAMES + 1);
    localparam int LW = $clog2(LIGHT_MIN_CYCLES + 1);

    localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FW-1:0] FIRST_SENSE = FW'(SENSE_START_FRAME);
    localparam logic [FW-1:0] LAST_FRAME  = FW'(TARGET_FRAMES - 1);
    localparam logic [FW-1:0] FRAME_ONE   = FW'(1);
    localparam logic [LW-1:0] RUN_HIT     = LW'(LIGHT_MIN_CYCLES - 1);
    localparam logic [LW-1:0] RUN_MAX     = LW'(LIGHT_MIN_CYCLES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SENSE    = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic          trig_m;
    logic          trig_s;
    logic          light_m;
    logic          light_s;
    logic [CW-1:0] cnt;
    logic          trig_db;
    logic          trig_db_q;
    logic          trig_edge;

    logic [FW-1:0] frame_idx;
    logic [LW-1:0] light_run;

    logic start_shot;
    logic window_open;
    logic window_end;
    logic light_hit;
    logic leave_cooldown;

    // Two-flop synchronisers for the asynchronous trigger and photodiode
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_m  <= 1'b0;
            trig_s  <= 1'b0;
            light_m <= 1'b0;
            light_s <= 1'b0;
        end else begin
            trig_m  <= trigger_in;
            trig_s  <= trig_m;
            light_m <= light_in;
            light_s <= light_m;
        end
    end

    // Debouncer: the level must hold for DEBOUNCE_CYCLES samples before trig_db follows it
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            trig_db   <= 1'b0;
            trig_db_q <= 1'b0;
        end else begin
            trig_db_q <= trig_db;
            if (trig_s == trig_db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                trig_db <= trig_s;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign trig_edge = trig_db & ~trig_db_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_shot) begin
                    next_state = SENSE;
                end
            end
            SENSE: begin
                if (!gun_is_connected) begin
                    next_state = IDLE;
                end else if (window_end) begin
                    next_state = COOLDOWN;
                end
            end
            COOLDOWN: begin
                if (!gun_is_connected || leave_cooldown) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The frame boundary cycle itself is excluded so that a window end always wins over a light sample
    always_comb begin
        busy           = (state != IDLE);
        start_shot     = (state == IDLE) && trig_edge && gun_is_connected;
        window_end     = (state == SENSE) && new_frame && (frame_idx == LAST_FRAME);
        window_open    = (state == SENSE) && (frame_idx >= FIRST_SENSE) &&
                         (frame_idx <= LAST_FRAME) && !duck_hit && !new_frame;
        light_hit      = window_open && light_s && (light_run == RUN_HIT);
        leave_cooldown = (state == COOLDOWN) && !trig_db;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shot_fired  <= 1'b0;
            shot_missed <= 1'b0;
            duck_hit    <= 1'b0;
            frame_idx   <= '0;
            light_run   <= '0;
        end else begin
            shot_fired  <= start_shot;
            shot_missed <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_shot) begin
                        frame_idx <= FRAME_ONE;
                        light_run <= '0;
                    end
                end
                SENSE: begin
                    if (!gun_is_connected) begin
                        duck_hit  <= 1'b0;
                        frame_idx <= '0;
                        light_run <= '0;
                    end else if (window_end) begin
                        frame_idx   <= '0;
                        light_run   <= '0;
                        shot_missed <= !duck_hit;
                    end else begin
                        if (new_frame) begin
                            frame_idx <= frame_idx + 1'b1;
                        end
                        if (window_open && light_s) begin
                            light_run <= (light_run == RUN_MAX) ? RUN_MAX : light_run + 1'b1;
                        end else begin
                            light_run <= '0;
                        end
                        if (light_hit) begin
                            duck_hit <= 1'b1;
                        end
                    end
                end
                COOLDOWN: begin
                    if (!gun_is_connected || leave_cooldown) begin
                        duck_hit  <= 1'b0;
                        frame_idx <= '0;
                        light_run <= '0;
                    end
                end
                default: begin
                    duck_hit  <= 1'b0;
                    frame_idx <= '0;
                    light_run <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gun_hit_detector.sv
// Scoreboard bench for gun_hit_detector: directed stimulus queues expected output events with
// their cycle numbers; a negedge monitor pops and compares every observed event.
module tb_gun_hit_detector;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic trigger_in = 1'b0;
    logic light_in = 1'b0;
    logic gun_is_connected = 1'b1;
    logic new_frame = 1'b0;
    logic shot_fired;
    logic duck_hit;
    logic shot_missed;
    logic busy;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef enum int {
        EV_SHOT, EV_BUSY_RISE, EV_HIT_RISE, EV_MISS, EV_HIT_FALL, EV_BUSY_FALL
    } ev_t;

    typedef struct {
        ev_t kind;
        int  at;
    } exp_t;

    exp_t exp_q[$];

    gun_hit_detector #(
        .DEBOUNCE_CYCLES(4),
        .TARGET_FRAMES(10),
        .SENSE_START_FRAME(2),
        .LIGHT_MIN_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .trigger_in(trigger_in),
        .light_in(light_in),
        .gun_is_connected(gun_is_connected),
        .new_frame(new_frame),
        .shot_fired(shot_fired),
        .duck_hit(duck_hit),
        .shot_missed(shot_missed),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame pulse is sampled by every edge whose number is a multiple of 50
    initial begin
        forever begin
            @(posedge clk);
            #1;
            new_frame = ((cyc + 1) % 50 == 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish by 1800", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic expect_ev(input ev_t k, input int at);
        exp_t e;
        e.kind = k;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic match_ev(input ev_t k);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s at cycle %0d, required no event", k.name(), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.at != cyc) begin
                errors++;
                $display("FAIL event_order: got %s at cycle %0d, required %s at cycle %0d",
                         k.name(), cyc, e.kind.name(), e.at);
            end
        end
    endtask

    logic busy_q = 1'b0;
    logic hit_q  = 1'b0;

    always @(negedge clk) begin
        if (shot_fired)          match_ev(EV_SHOT);
        if (busy && !busy_q)     match_ev(EV_BUSY_RISE);
        if (duck_hit && !hit_q)  match_ev(EV_HIT_RISE);
        if (shot_missed)         match_ev(EV_MISS);
        if (!duck_hit && hit_q)  match_ev(EV_HIT_FALL);
        if (!busy && busy_q)     match_ev(EV_BUSY_FALL);
        if (shot_fired && shot_missed) begin
            checks++;
            errors++;
            $display("FAIL pulse_overlap: shot_fired=1 shot_missed=1 at cycle %0d, required not both", cyc);
        end
        busy_q = busy;
        hit_q  = duck_hit;
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compares {shot_fired, duck_hit, shot_missed, busy} mid-cycle
    task automatic check_at(input int c, input string nm, input logic [3:0] req);
        logic [3:0] act;
        wait_cyc(c);
        @(negedge clk);
        act = {shot_fired, duck_hit, shot_missed, busy};
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: outputs {shot,hit,miss,busy}=%b at cycle %0d, required %b", nm, act, cyc, req);
        end
    endtask

    initial begin
        // Reset held while the raw inputs toggle
        for (int k = 0; k < 3; k++) begin
            trigger_in       = ~trigger_in;
            light_in         = ~light_in;
            gun_is_connected = ~gun_is_connected;
            @(negedge clk);
            checks++;
            if ({shot_fired, duck_hit, shot_missed, busy} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_outputs: {shot,hit,miss,busy}=%b at cycle %0d, required 0000",
                         {shot_fired, duck_hit, shot_missed, busy}, cyc);
            end
            @(posedge clk);
            #1;
        end
        rst              = 1'b0;
        trigger_in       = 1'b0;
        light_in         = 1'b0;
        gun_is_connected = 1'b1;
        check_at(6, "idle_after_reset", 4'b0000);
        check_at(8, "idle_after_reset_2", 4'b0000);

        // Bouncing trigger, then a clean hold; light only in frame 1 so the shot misses
        for (int i = 0; i < 10; i++) begin
            wait_cyc(10 + 2 * i);
            trigger_in = ~trigger_in;
        end
        wait_cyc(30);
        trigger_in = 1'b1;
        expect_ev(EV_SHOT, 37);
        expect_ev(EV_BUSY_RISE, 37);
        wait_cyc(38);
        light_in = 1'b1;
        expect_ev(EV_MISS, 450);
        wait_cyc(48);
        light_in = 1'b0;
        check_at(300, "sensing_no_hit", 4'b0001);
        check_at(455, "cooldown_trigger_held", 4'b0001);
        wait_cyc(460);
        trigger_in = 1'b0;
        expect_ev(EV_BUSY_FALL, 467);

        // Hit in frame 3
        wait_cyc(480);
        trigger_in = 1'b1;
        expect_ev(EV_SHOT, 487);
        expect_ev(EV_BUSY_RISE, 487);
        wait_cyc(570);
        light_in = 1'b1;
        expect_ev(EV_HIT_RISE, 575);
        wait_cyc(575);
        light_in = 1'b0;
        check_at(905, "hit_held_after_window", 4'b0101);
        wait_cyc(910);
        trigger_in = 1'b0;
        expect_ev(EV_HIT_FALL, 917);
        expect_ev(EV_BUSY_FALL, 917);

        // Broken light run in frame 4: two, gap, two
        wait_cyc(930);
        trigger_in = 1'b1;
        expect_ev(EV_SHOT, 937);
        expect_ev(EV_BUSY_RISE, 937);
        wait_cyc(1070);
        light_in = 1'b1;
        wait_cyc(1072);
        light_in = 1'b0;
        wait_cyc(1073);
        light_in = 1'b1;
        wait_cyc(1075);
        light_in = 1'b0;
        expect_ev(EV_MISS, 1350);
        wait_cyc(1410);
        trigger_in = 1'b0;
        expect_ev(EV_BUSY_FALL, 1417);

        // Gun unplugged in frame 5, then a pull while unplugged and a replug with trigger held
        wait_cyc(1430);
        trigger_in = 1'b1;
        expect_ev(EV_SHOT, 1437);
        expect_ev(EV_BUSY_RISE, 1437);
        wait_cyc(1620);
        gun_is_connected = 1'b0;
        expect_ev(EV_BUSY_FALL, 1621);
        wait_cyc(1630);
        trigger_in = 1'b0;
        wait_cyc(1650);
        trigger_in = 1'b1;
        check_at(1665, "disconnected_no_fire", 4'b0000);
        wait_cyc(1700);
        gun_is_connected = 1'b1;
        check_at(1705, "replug_no_autofire", 4'b0000);
        wait_cyc(1710);
        trigger_in = 1'b0;

        // Reset in the middle of sensing
        wait_cyc(1730);
        trigger_in = 1'b1;
        expect_ev(EV_SHOT, 1737);
        expect_ev(EV_BUSY_RISE, 1737);
        wait_cyc(1760);
        rst        = 1'b1;
        trigger_in = 1'b0;
        expect_ev(EV_BUSY_FALL, 1761);
        check_at(1761, "mid_reset_outputs", 4'b0000);
        wait_cyc(1762);
        rst = 1'b0;
        check_at(1790, "after_mid_reset", 4'b0000);

        wait_cyc(1800);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: %0d expected events never seen (first %s at cycle %0d), required 0",
                     exp_q.size(), exp_q[0].kind.name(), exp_q[0].at);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
